// File: rtl/addsub_nibble_seq.sv
// Nibble-serial add/subtract sequencer: one 4-bit slice is reused once per cycle,
// least-significant nibble first, with the inter-nibble carry held in a register.
module addsub_nibble_seq #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_zero,
    output logic             o_busy
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sub;
    logic [KW-1:0]    r_k;
    logic             r_c;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic [3:0]       w_aNib;
    logic [3:0]       w_bNib;
    logic [3:0]       w_low;
    logic             w_c3;
    logic [3:0]       w_sum;
    logic             w_cNext;
    logic             w_lastNib;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        o_ready     = 1'b0;
        o_valid     = 1'b0;
        o_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                o_busy = 1'b1;
                if (w_lastNib) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                o_busy  = 1'b1;
                o_valid = 1'b1;
                if (i_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // The slice is split at bit 2 so the carry into the top bit of the word
    // (needed for signed overflow) is visible during the last nibble.
    always_comb begin
        w_lastNib = (r_k == LAST_K);
        w_aNib    = r_a[{r_k, 2'b00} +: 4];
        w_bNib    = r_b[{r_k, 2'b00} +: 4] ^ {4{r_sub}};
        w_low     = {1'b0, w_aNib[2:0]} + {1'b0, w_bNib[2:0]} + {3'b000, r_c};
        w_c3      = w_low[3];
        w_sum     = {w_aNib[3] ^ w_bNib[3] ^ w_c3, w_low[2:0]};
        w_cNext   = (w_aNib[3] & w_bNib[3]) | (w_aNib[3] & w_c3) | (w_bNib[3] & w_c3);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sub    <= 1'b0;
            r_k      <= '0;
            r_c      <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_a      <= i_a;
                        r_b      <= i_b;
                        r_sub    <= i_sub;
                        r_k      <= '0;
                        r_c      <= i_sub;
                        r_result <= '0;
                        r_cout   <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_zero   <= 1'b0;
                    end
                end
                RUN: begin
                    r_result[{r_k, 2'b00} +: 4] <= w_sum;
                    r_c                         <= w_cNext;
                    if (w_lastNib) begin
                        // Lower nibbles are already final, so zero can be judged here.
                        r_k    <= '0;
                        r_cout <= w_cNext ^ r_sub;
                        r_ovf  <= w_c3 ^ w_cNext;
                        r_zero <= ({w_sum, r_result[WIDTH-5:0]} == '0);
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_result = r_result;
    assign o_cout   = r_cout;
    assign o_ovf    = r_ovf;
    assign o_zero   = r_zero;

endmodule

// File: tb/tb_addsub_nibble_seq.sv
// Directed and randomised bench for the nibble-serial add/subtract sequencer.
module tb_addsub_nibble_seq;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        i_sub;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_cout;
    logic        o_ovf;
    logic        o_zero;
    logic        o_busy;

    int assertCount = 0;
    int failCount   = 0;
    int cycleCount  = 0;
    int lastAccept  = 0;

    addsub_nibble_seq #(.WIDTH(32)) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_sub    (i_sub),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_cout   (o_cout),
        .o_ovf    (o_ovf),
        .o_zero   (o_zero),
        .o_busy   (o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cycleCount = cycleCount + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference written from arithmetic definitions, not from the slice structure.
    function automatic logic [34:0] refModel(input logic [31:0] a, input logic [31:0] b,
                                             input logic sub);
        logic [32:0] wide;
        logic [31:0] r;
        logic        cout;
        logic        ovf;
        if (!sub) begin
            wide = {1'b0, a} + {1'b0, b};
            r    = wide[31:0];
            cout = wide[32];
            ovf  = (a[31] == b[31]) && (r[31] != a[31]);
        end else begin
            r    = a - b;
            cout = (a < b);
            ovf  = (a[31] != b[31]) && (r[31] != a[31]);
        end
        return {cout, ovf, (r == 32'h0), r};
    endfunction

    // Called at a negedge; returns at the negedge just after the accept edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sub);
        i_a     = a;
        i_b     = b;
        i_sub   = sub;
        i_valid = 1'b1;
        for (int n = 0; n < 40 && !o_ready; n++) @(negedge i_clk);
        checkOutput("acceptReady", 64'(o_ready), 64'd1);
        @(posedge i_clk);
        @(negedge i_clk);
        lastAccept = cycleCount;
        i_valid    = 1'b0;
    endtask

    task automatic waitResult(input string tag);
        for (int n = 0; n < 40; n++) begin
            @(negedge i_clk);
            if (o_valid) break;
        end
        checkOutput({tag, "_validSeen"}, 64'(o_valid), 64'd1);
        checkOutput({tag, "_latency"}, 64'(cycleCount - lastAccept), 64'd8);
    endtask

    task automatic runDirected(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic sub, input logic [31:0] expRes,
                               input logic expCout, input logic expOvf, input logic expZero);
        applyStimulus(a, b, sub);
        checkOutput({tag, "_busy"}, 64'({o_busy, o_ready}), 64'b10);
        waitResult(tag);
        checkOutput({tag, "_result"}, 64'(o_result), 64'(expRes));
        checkOutput({tag, "_flags"}, 64'({o_cout, o_ovf, o_zero}),
                    64'({expCout, expOvf, expZero}));
        @(negedge i_clk);
        checkOutput({tag, "_validPulse"}, 64'({o_valid, o_ready, o_busy}), 64'b010);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        int          prevAccept;

        i_reset = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_a     = '0;
        i_b     = '0;
        i_sub   = 1'b0;
        repeat (3) @(negedge i_clk);
        checkOutput("reset_handshake", 64'({o_ready, o_valid, o_busy}), 64'b100);
        checkOutput("reset_result", 64'(o_result), 64'd0);
        checkOutput("reset_flags", 64'({o_cout, o_ovf, o_zero}), 64'b000);
        i_reset = 1'b0;
        @(negedge i_clk);

        $display("[TB] directed vectors");
        runDirected("addWrap", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        runDirected("subBorrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        runDirected("addOvf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        runDirected("subOvf", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        runDirected("subEqual", 32'h0000_1234, 32'h0000_1234, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1);

        $display("[TB] backpressure and ignored requests");
        i_ready = 1'b0;
        applyStimulus(32'h0000_0010, 32'h0000_0020, 1'b0);
        i_a     = 32'hFFFF_FFFF;
        i_b     = 32'hFFFF_FFFF;
        i_sub   = 1'b1;
        i_valid = 1'b1;
        @(negedge i_clk);
        checkOutput("bp_runIgnore", 64'({o_ready, o_busy}), 64'b01);
        i_valid = 1'b0;
        waitResult("bp");
        checkOutput("bp_result", 64'(o_result), 64'h30);
        for (int i = 0; i < 5; i++) begin
            i_valid = i[0];
            @(negedge i_clk);
            checkOutput("bp_hold", 64'({o_valid, o_ready, o_cout, o_ovf, o_zero, o_result}),
                        {27'd0, 5'b10000, 32'h0000_0030});
        end
        i_a     = 32'h0000_0100;
        i_b     = 32'h0000_0001;
        i_sub   = 1'b1;
        i_valid = 1'b1;
        i_ready = 1'b1;
        @(negedge i_clk);
        checkOutput("bp_retire", 64'({o_valid, o_ready, o_busy}), 64'b010);
        checkOutput("bp_keepInIdle", 64'(o_result), 64'h30);
        @(negedge i_clk);
        lastAccept = cycleCount;
        i_valid    = 1'b0;
        checkOutput("bp_lateAccept", 64'({o_ready, o_busy}), 64'b01);
        checkOutput("bp_clearOnAccept", 64'(o_result), 64'd0);
        waitResult("bp2");
        checkOutput("bp2_result", 64'({o_cout, o_ovf, o_zero, o_result}),
                    {29'd0, 3'b000, 32'h0000_00FF});
        @(negedge i_clk);

        $display("[TB] reset during RUN");
        applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        checkOutput("rst_handshake", 64'({o_ready, o_valid, o_busy}), 64'b100);
        checkOutput("rst_outputs", 64'({o_cout, o_ovf, o_zero, o_result}), 64'd0);
        i_reset = 1'b0;
        runDirected("afterRst", 32'd2, 32'd3, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0);

        $display("[TB] back-to-back random operations");
        prevAccept = 0;
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            applyStimulus(ra, rb, rs);
            if (i > 0) checkOutput("rand_spacing", 64'(lastAccept - prevAccept), 64'd10);
            prevAccept = lastAccept;
            waitResult("rand");
            checkOutput("rand_result", 64'({o_cout, o_ovf, o_zero, o_result}),
                        64'(refModel(ra, rb, rs)));
        end
        repeat (2) @(negedge i_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
